bo_control_sequencer: RTL

- Control sequencer for the Bloco Operativo (BO) datapath.
- Accepts one 16-bit instruction per start handshake and decodes it.
- Drives the 2-bit selects of the two registered 4:1 operand multiplexers (operand A, operand B), the ALU operation, the immediate path and the register-bank write strobe.
- Sits directly upstream of the operand muxes and waits out their registered latency before committing results.

---
 rtl/bo_pkg.sv | 52 +++++
 rtl/bo_instr_decode.sv | 45 ++++
 rtl/bo_control_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bo_pkg.sv
// Shared definitions for the BO control sequencer: opcodes, ALU codes, states, field positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bo_pkg;

  // Opcodes carried in instr[15:13]
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_MOV  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  // ALU operation codes driven on alu_op
  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;

  // Instruction field positions (LSB and width). srcB and imm overlap on bit 7;
  // only LDI interprets the low byte as an immediate.
  localparam int OPC_LSB  = 13;
  localparam int OPC_W    = 3;
  localparam int DST_LSB  = 11;
  localparam int SRCA_LSB = 9;
  localparam int SRCB_LSB = 7;
  localparam int REG_W    = 2;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 8;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUXWAIT = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  // Path an accepted instruction takes through the sequencer
  typedef enum logic [1:0] {
    CLS_NOP  = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_LDI  = 2'd2,
    CLS_HALT = 2'd3
  } seq_class_e;

endpackage

// File: rtl/bo_instr_decode.sv
// Combinational decode of one BO instruction into mux selects, ALU op, immediate and path class.
// Latency: 0 cycles; the sequencer registers every output on its capture edge.
// Backpressure: none; pure function of instr.
module bo_instr_decode
  import bo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] instr,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       wr_addr,
  output logic [WIDTH-1:0] imm,
  output logic             imm_en,
  output seq_class_e       cls
);

  logic [2:0] opcode;

  assign opcode = instr[OPC_LSB +: OPC_W];

  // Field extraction is unconditional; opcode only picks ALU op, imm source and path.
  always_comb begin
    sel_a   = instr[SRCA_LSB +: REG_W];
    sel_b   = instr[SRCB_LSB +: REG_W];
    wr_addr = instr[DST_LSB +: REG_W];
    imm     = {{(WIDTH-IMM_W){1'b0}}, instr[IMM_LSB +: IMM_W]};
    alu_op  = ALU_PASS_A;
    imm_en  = 1'b0;
    cls     = CLS_NOP;
    case (opcode)
      OP_NOP:  cls = CLS_NOP;
      OP_ADD:  begin alu_op = ALU_ADD;    cls = CLS_ALU; end
      OP_SUB:  begin alu_op = ALU_SUB;    cls = CLS_ALU; end
      OP_AND:  begin alu_op = ALU_AND;    cls = CLS_ALU; end
      OP_OR:   begin alu_op = ALU_OR;     cls = CLS_ALU; end
      OP_LDI:  begin imm_en = 1'b1;       cls = CLS_LDI; end
      OP_MOV:  begin alu_op = ALU_PASS_A; cls = CLS_ALU; end
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/bo_control_sequencer.sv
// Sequences one BO instruction: capture, operand-mux wait, ALU settle, write strobe, done pulse.
// Latency: ALU ops wr_en at start+MUX_LAT+2 and done one later; LDI wr_en +1/done +2; NOP done +1.
// Backpressure: start is only sampled in IDLE; while busy or halted it is ignored and fields hold.
module bo_control_sequencer
  import bo_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MUX_LAT = 1   // operand mux register latency, 1..3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] instr,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic [2:0]       alu_op,
  output logic             imm_en,
  output logic [WIDTH-1:0] imm,
  output logic             wr_en,
  output logic [1:0]       wr_addr,
  output logic             busy,
  output logic             done,
  output logic             halted
);

  // Last count value spent in MUXWAIT before moving on to EXEC
  localparam logic [1:0] LAT_LAST = 2'(MUX_LAT - 1);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             capture;

  logic [1:0]       dec_sel_a, dec_sel_b, dec_wr_addr;
  logic [2:0]       dec_alu_op;
  logic [WIDTH-1:0] dec_imm;
  logic             dec_imm_en;
  seq_class_e       dec_cls;

  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             imm_en_q, imm_en_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [1:0]       wr_addr_q, wr_addr_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;

  bo_instr_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .instr   (instr),
    .sel_a   (dec_sel_a),
    .sel_b   (dec_sel_b),
    .alu_op  (dec_alu_op),
    .wr_addr (dec_wr_addr),
    .imm     (dec_imm),
    .imm_en  (dec_imm_en),
    .cls     (dec_cls)
  );

  // Next state, latency counter, capture decision and next output values.
  // Status outputs are derived from the current state, so they lag it by one edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          unique case (dec_cls)
            CLS_ALU: begin
              state_d = ST_MUXWAIT;
              cnt_d   = '0;
            end
            CLS_LDI:  state_d = ST_WRITE;
            CLS_NOP:  state_d = ST_DONE;
            CLS_HALT: state_d = ST_HALT;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_MUXWAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = ST_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase

    sel_a_d   = capture ? dec_sel_a   : sel_a_q;
    sel_b_d   = capture ? dec_sel_b   : sel_b_q;
    alu_op_d  = capture ? dec_alu_op  : alu_op_q;
    imm_en_d  = capture ? dec_imm_en  : imm_en_q;
    imm_d     = capture ? dec_imm     : imm_q;
    wr_addr_d = capture ? dec_wr_addr : wr_addr_q;

    wr_en_d  = (state_q == ST_WRITE);
    done_d   = (state_q == ST_DONE);
    busy_d   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    halted_d = (state_q == ST_HALT);
  end

  // State, counter and output registers; reset clears everything, dropping any pending strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      alu_op_q  <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      alu_op_q  <= alu_op_d;
      imm_en_q  <= imm_en_d;
      imm_q     <= imm_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      halted_q  <= halted_d;
    end
  end

  assign sel_a   = sel_a_q;
  assign sel_b   = sel_b_q;
  assign alu_op  = alu_op_q;
  assign imm_en  = imm_en_q;
  assign imm     = imm_q;
  assign wr_addr = wr_addr_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign halted  = halted_q;

endmodule
